// File: rtl/dcache_pkg.sv
// Shared D-cache definitions used by the writeback engine.
//   BANK_NUM         : data array banks per line (one beat per bank)
//   LINE_OFFSET_BITS : byte-offset bits of a 64-byte line
//   BEAT_CNT_WIDTH   : width of the burst beat counter
//   wb_state_t       : writeback engine FSM states
package dcache_pkg;

    localparam int unsigned BANK_NUM         = 8;
    localparam int unsigned LINE_OFFSET_BITS = 6;
    localparam int unsigned BEAT_CNT_WIDTH   = $clog2(BANK_NUM);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        CAP   = 3'd2,
        SEND  = 3'd3,
        WAITB = 3'd4
    } wb_state_t;

endpackage : dcache_pkg

// File: rtl/dcache_wb_engine.sv
// Writeback (eviction) engine for the 2-way, 8-bank D-cache data array.
// Reads a whole victim line in one array access, buffers it locally and
// streams it to memory as an 8-beat valid/ready write burst, then waits
// for the write response and pulses done.
//
// Ports:
//   clock, reset                 : clock, asynchronous active-high reset
//   req_valid/req_ready          : evict request handshake
//   req_way/req_set/req_tag      : victim way, set index and tag
//   arr_ce_way/arr_ce_bank       : data array way / bank enables
//   arr_we                       : data array write enable (always 0)
//   arr_readsetaddr              : data array read set address
//   arr_dout_bank                : data array bank outputs (1-cycle latency)
//   mem_wvalid/mem_wready        : write beat handshake
//   mem_waddr/mem_wdata/mem_wlast: line address, beat data, final beat
//   mem_bvalid/mem_bready        : write response handshake
//   done                         : one-cycle completion pulse
module dcache_wb_engine
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned TAG_WIDTH  = 17,
    localparam int unsigned PADDR_WIDTH = TAG_WIDTH + ADDR_WIDTH + LINE_OFFSET_BITS
) (
    input  logic                                  clock,
    input  logic                                  reset,

    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic                                  req_way,
    input  logic [ADDR_WIDTH-1:0]                 req_set,
    input  logic [TAG_WIDTH-1:0]                  req_tag,

    output logic [1:0]                            arr_ce_way,
    output logic [BANK_NUM-1:0]                   arr_ce_bank,
    output logic                                  arr_we,
    output logic [ADDR_WIDTH-1:0]                 arr_readsetaddr,
    input  logic [BANK_NUM-1:0][DATA_WIDTH-1:0]   arr_dout_bank,

    output logic                                  mem_wvalid,
    input  logic                                  mem_wready,
    output logic [PADDR_WIDTH-1:0]                mem_waddr,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    output logic                                  mem_wlast,
    input  logic                                  mem_bvalid,
    output logic                                  mem_bready,

    output logic                                  done
);

    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(BANK_NUM - 1);

    wb_state_t                             state_q, state_d;
    logic [BEAT_CNT_WIDTH-1:0]             cnt_q, cnt_d;
    logic [BANK_NUM-1:0][DATA_WIDTH-1:0]   line_q, line_d;
    logic                                  way_q, way_d;
    logic [ADDR_WIDTH-1:0]                 set_q, set_d;
    logic [TAG_WIDTH-1:0]                  tag_q, tag_d;

    logic                                  req_ready_d;
    logic [1:0]                            ce_way_d;
    logic [BANK_NUM-1:0]                   ce_bank_d;
    logic [ADDR_WIDTH-1:0]                 readsetaddr_d;
    logic                                  wvalid_d;
    logic [PADDR_WIDTH-1:0]                waddr_d;
    logic [DATA_WIDTH-1:0]                 wdata_d;
    logic                                  wlast_d;
    logic                                  bready_d;
    logic                                  done_d;

    // The engine only reads the array.
    assign arr_we = 1'b0;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath next values, and next values of the registered outputs.
    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        way_d   = way_q;
        set_d   = set_q;
        tag_d   = tag_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    way_d   = req_way;
                    set_d   = req_set;
                    tag_d   = req_tag;
                    state_d = RD;
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                // Array data for the RD-cycle access is valid now; never sampled again.
                line_d  = arr_dout_bank;
                state_d = SEND;
            end
            SEND: begin
                // mem_wvalid is high for the whole of SEND, so wready alone completes a beat.
                if (mem_wready) begin
                    cnt_d = cnt_q + BEAT_CNT_WIDTH'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = WAITB;
                    end
                end
            end
            WAITB: begin
                if (mem_bvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d   = (state_d == IDLE);
        ce_way_d      = (state_d == RD) ? (2'b01 << way_d) : 2'b00;
        ce_bank_d     = (state_d == RD) ? '1 : '0;
        readsetaddr_d = (state_d == RD) ? set_d : '0;
        wvalid_d      = (state_d == SEND);
        wdata_d       = (state_d == SEND) ? line_d[cnt_d] : '0;
        wlast_d       = (state_d == SEND) && (cnt_d == LAST_BEAT);
        waddr_d       = (state_d == SEND) ? {tag_d, set_d, LINE_OFFSET_BITS'(0)} : '0;
        bready_d      = (state_d == WAITB);
        done_d        = (state_q == WAITB) && mem_bvalid;
    end

    // Datapath and output registers; reset abandons any burst without a done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q           <= '0;
            line_q          <= '0;
            way_q           <= 1'b0;
            set_q           <= '0;
            tag_q           <= '0;
            req_ready       <= 1'b1;
            arr_ce_way      <= '0;
            arr_ce_bank     <= '0;
            arr_readsetaddr <= '0;
            mem_wvalid      <= 1'b0;
            mem_waddr       <= '0;
            mem_wdata       <= '0;
            mem_wlast       <= 1'b0;
            mem_bready      <= 1'b0;
            done            <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            line_q          <= line_d;
            way_q           <= way_d;
            set_q           <= set_d;
            tag_q           <= tag_d;
            req_ready       <= req_ready_d;
            arr_ce_way      <= ce_way_d;
            arr_ce_bank     <= ce_bank_d;
            arr_readsetaddr <= readsetaddr_d;
            mem_wvalid      <= wvalid_d;
            mem_waddr       <= waddr_d;
            mem_wdata       <= wdata_d;
            mem_wlast       <= wlast_d;
            mem_bready      <= bready_d;
            done            <= done_d;
        end
    end

endmodule : dcache_wb_engine

// File: tb/tb_dcache_wb_engine.sv
// Directed self-checking bench for dcache_wb_engine with a behavioural
// 1-cycle-latency data array that returns garbage whenever it is not read.
module tb_dcache_wb_engine;

    logic             clock;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_way;
    logic [8:0]       req_set;
    logic [16:0]      req_tag;
    logic [1:0]       arr_ce_way;
    logic [7:0]       arr_ce_bank;
    logic             arr_we;
    logic [8:0]       arr_readsetaddr;
    logic [7:0][63:0] arr_dout_bank;
    logic             mem_wvalid;
    logic             mem_wready;
    logic [31:0]      mem_waddr;
    logic [63:0]      mem_wdata;
    logic             mem_wlast;
    logic             mem_bvalid;
    logic             mem_bready;
    logic             done;

    int tests = 0;
    int fails = 0;
    int lat;

    dcache_wb_engine dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_way         (req_way),
        .req_set         (req_set),
        .req_tag         (req_tag),
        .arr_ce_way      (arr_ce_way),
        .arr_ce_bank     (arr_ce_bank),
        .arr_we          (arr_we),
        .arr_readsetaddr (arr_readsetaddr),
        .arr_dout_bank   (arr_dout_bank),
        .mem_wvalid      (mem_wvalid),
        .mem_wready      (mem_wready),
        .mem_waddr       (mem_waddr),
        .mem_wdata       (mem_wdata),
        .mem_wlast       (mem_wlast),
        .mem_bvalid      (mem_bvalid),
        .mem_bready      (mem_bready),
        .done            (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Array contents: way1 set 0x1A5 holds A0..A7, every other line encodes way/set/bank.
    function automatic logic [63:0] model_word(input logic way, input logic [8:0] set, input int b);
        if (way && set == 9'h1A5) return 64'hA0 + 64'(b);
        return {8'hD0, 7'(0), way, 7'(0), set, 24'(0), 8'(b)};
    endfunction

    // Behavioural data array: full-line read with 1-cycle latency, random data otherwise.
    always @(posedge clock) begin
        for (int b = 0; b < 8; b++) begin
            if (arr_ce_bank == 8'hFF && (arr_ce_way == 2'b01 || arr_ce_way == 2'b10))
                arr_dout_bank[b] <= model_word(arr_ce_way[1], arr_readsetaddr, b);
            else
                arr_dout_bank[b] <= {$urandom, $urandom};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Entered at the negedge right after the accept edge (engine in RD); returns at the
    // negedge of the done cycle. cyc = clock edges from the accept edge to done visible.
    task automatic run_wb(input logic way, input logic [8:0] set, input logic [16:0] tag,
                          input bit stall, input int bdelay, input bit spurious,
                          output int cyc);
        logic [31:0] exp_addr;
        int beat;
        int k;
        logic rdy;
        exp_addr = {tag, set, 6'b0};
        cyc = 0;

        check("rd_ce_way", 64'(arr_ce_way), way ? 64'h2 : 64'h1);
        check("rd_ce_bank", 64'(arr_ce_bank), 64'hFF);
        check("rd_setaddr", 64'(arr_readsetaddr), 64'(set));
        check("rd_req_ready", 64'(req_ready), 64'h0);
        check("rd_done", 64'(done), 64'h0);
        check("rd_we", 64'(arr_we), 64'h0);
        if (spurious) begin
            req_valid = 1'b1;
            req_way   = ~way;
            req_set   = 9'h0F0;
            req_tag   = 17'h00001;
        end

        tick(); cyc++;
        check("cap_ce_way", 64'(arr_ce_way), 64'h0);
        check("cap_ce_bank", 64'(arr_ce_bank), 64'h0);
        check("cap_wvalid", 64'(mem_wvalid), 64'h0);
        check("cap_req_ready", 64'(req_ready), 64'h0);

        tick(); cyc++;
        if (spurious) begin
            req_valid  = 1'b0;
            mem_bvalid = 1'b1;
        end

        beat = 0;
        k = 0;
        while (beat < 8 && k < 200) begin
            check("send_wvalid", 64'(mem_wvalid), 64'h1);
            check("send_wdata", mem_wdata, model_word(way, set, beat));
            check("send_waddr", 64'(mem_waddr), 64'(exp_addr));
            check("send_wlast", 64'(mem_wlast), (beat == 7) ? 64'h1 : 64'h0);
            check("send_bready", 64'(mem_bready), 64'h0);
            check("send_req_ready", 64'(req_ready), 64'h0);
            rdy = stall ? ((k % 3) == 0) : 1'b1;
            mem_wready = rdy;
            tick(); cyc++;
            if (spurious) mem_bvalid = 1'b0;
            if (rdy) beat++;
            k++;
        end
        check("burst_beats", 64'(beat), 64'd8);
        mem_wready = 1'b0;

        check("waitb_wvalid", 64'(mem_wvalid), 64'h0);
        check("waitb_wlast", 64'(mem_wlast), 64'h0);
        check("waitb_bready", 64'(mem_bready), 64'h1);
        check("waitb_req_ready", 64'(req_ready), 64'h0);
        check("waitb_done", 64'(done), 64'h0);
        for (int d = 0; d < bdelay; d++) begin
            mem_bvalid = 1'b0;
            tick(); cyc++;
            check("late_bready", 64'(mem_bready), 64'h1);
            check("late_req_ready", 64'(req_ready), 64'h0);
            check("late_done", 64'(done), 64'h0);
        end
        mem_bvalid = 1'b1;
        tick(); cyc++;
        mem_bvalid = 1'b0;
        check("done_pulse", 64'(done), 64'h1);
        check("done_req_ready", 64'(req_ready), 64'h1);
        check("done_bready", 64'(mem_bready), 64'h0);
    endtask

    task automatic request(input logic way, input logic [8:0] set, input logic [16:0] tag);
        req_valid = 1'b1;
        req_way   = way;
        req_set   = set;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_way    = 1'b0;
        req_set    = '0;
        req_tag    = '0;
        mem_wready = 1'b0;
        mem_bvalid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_req_ready", 64'(req_ready), 64'h1);
        check("rst_wvalid", 64'(mem_wvalid), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_ce_way", 64'(arr_ce_way), 64'h0);
        check("rst_ce_bank", 64'(arr_ce_bank), 64'h0);
        check("rst_bready", 64'(mem_bready), 64'h0);
        check("rst_we", 64'(arr_we), 64'h0);
        check("rst_waddr", 64'(mem_waddr), 64'h0);

        // Basic: way1 set 0x1A5 tag 0x1234, no stalls
        check("basic_addr_const", 64'({17'h1234, 9'h1A5, 6'b0}), 64'h091A6940);
        request(1'b1, 9'h1A5, 17'h1234);
        run_wb(1'b1, 9'h1A5, 17'h1234, 1'b0, 0, 1'b0, lat);
        check("basic_latency", 64'(lat), 64'd11);
        tick();
        check("basic_done_once", 64'(done), 64'h0);
        check("basic_idle_ready", 64'(req_ready), 64'h1);

        // Backpressure: wready 1,0,0,1,0,0,...
        request(1'b1, 9'h1A5, 17'h1FFFF);
        run_wb(1'b1, 9'h1A5, 17'h1FFFF, 1'b1, 0, 1'b0, lat);
        check("stall_latency", 64'(lat), 64'd25);
        tick();
        check("stall_done_once", 64'(done), 64'h0);

        // Late response: bvalid 5 cycles after WAITB entry
        request(1'b0, 9'h0AB, 17'h000F0);
        run_wb(1'b0, 9'h0AB, 17'h000F0, 1'b0, 5, 1'b0, lat);
        check("late_latency", 64'(lat), 64'd16);
        tick();
        check("late_done_once", 64'(done), 64'h0);

        // Back-to-back: second request held valid through the first burst
        request(1'b1, 9'h1A5, 17'h1234);
        req_valid = 1'b1;
        req_way   = 1'b0;
        req_set   = 9'h000;
        req_tag   = 17'h0;
        run_wb(1'b1, 9'h1A5, 17'h1234, 1'b0, 0, 1'b0, lat);
        tick();
        req_valid = 1'b0;
        check("b2b_accept_done_low", 64'(done), 64'h0);
        run_wb(1'b0, 9'h000, 17'h0, 1'b0, 0, 1'b0, lat);
        check("b2b_latency", 64'(lat), 64'd11);
        tick();

        // Reset mid-SEND after four handshakes
        request(1'b1, 9'h1A5, 17'h0ABC);
        tick();
        tick();
        mem_wready = 1'b1;
        repeat (4) tick();
        mem_wready = 1'b0;
        check("pre_rst_wdata", mem_wdata, 64'hA4);
        check("pre_rst_wvalid", 64'(mem_wvalid), 64'h1);
        mem_bvalid = 1'b1;
        reset = 1'b1;
        #1;
        check("midrst_wvalid", 64'(mem_wvalid), 64'h0);
        check("midrst_req_ready", 64'(req_ready), 64'h1);
        check("midrst_done", 64'(done), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("postrst_done", 64'(done), 64'h0);
        check("postrst_req_ready", 64'(req_ready), 64'h1);
        check("postrst_wvalid", 64'(mem_wvalid), 64'h0);
        mem_bvalid = 1'b0;
        request(1'b1, 9'h1A5, 17'h0ABC);
        run_wb(1'b1, 9'h1A5, 17'h0ABC, 1'b0, 0, 1'b0, lat);
        check("postrst_latency", 64'(lat), 64'd11);
        tick();

        // Spurious req_valid in RD/CAP and bvalid in SEND are ignored
        request(1'b0, 9'h055, 17'h0F0F);
        run_wb(1'b0, 9'h055, 17'h0F0F, 1'b0, 0, 1'b1, lat);
        check("spur_latency", 64'(lat), 64'd11);
        tick();
        check("spur_idle_ready", 64'(req_ready), 64'h1);
        check("spur_no_relatch", 64'(arr_ce_way), 64'h0);
        check("spur_done_once", 64'(done), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_dcache_wb_engine
